// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the 8-bit synchronous FIFO and its UART TX consumer.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;

    // consumer side: watches the flags and data, owns the read strobe
    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    // FIFO side
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter draining an 8-bit synchronous FIFO, one byte per frame, LSB first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for tx_en with a non-empty FIFO
// ST_READ  | fifo_rd_en high for exactly this cycle
// ST_LATCH | FIFO data valid; loaded into the shift register at cycle end
// ST_START | start bit (line low) for CLKS_PER_BIT cycles
// ST_DATA  | 8 data bits, CLKS_PER_BIT cycles each, shift register shifts right
// ST_STOP  | stop bit (line high); frame_done in its final cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    // Next-state, baud counter and shift register; outputs are derived from the
    // next state so that every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (tx_en && !fifo.fifo_empty) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cnt_d   = '0;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                cnt_d   = '0;
                shift_d = fifo.fifo_data;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        tx_d = 1'b1;
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shift_d[0];
        end
        rd_en_d      = (state_d == ST_READ);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_STOP) && (cnt_d == CNT_MAX);
    end

    // State and registered outputs; reset forces the line high immediately and
    // drops any byte already popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo.fifo_rd_en = rd_en_q;
    assign tx              = tx_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (CLKS_PER_BIT 2, 4, 16) share one FIFO model;
// frames are checked against levels computed from the byte and the bit period.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] tx_en_v = 3'b000;
    logic [2:0] rd_v, tx_v, busy_v, fd_v, empty_v;
    logic [7:0] fifo_data_m = 8'h00;
    logic       q_empty_m = 1'b1;
    int         sel = 0;
    logic [7:0] q[$];

    int n_chk = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int bad_rd = 0;
    int pushes = 0;

    always #5 clk = ~clk;

    fifo_uart_tx_if f0();
    fifo_uart_tx_if f1();
    fifo_uart_tx_if f2();

    assign empty_v[0] = (sel != 0) || q_empty_m;
    assign empty_v[1] = (sel != 1) || q_empty_m;
    assign empty_v[2] = (sel != 2) || q_empty_m;
    assign f0.fifo_empty = empty_v[0];
    assign f1.fifo_empty = empty_v[1];
    assign f2.fifo_empty = empty_v[2];
    assign f0.fifo_data = fifo_data_m;
    assign f1.fifo_data = fifo_data_m;
    assign f2.fifo_data = fifo_data_m;
    assign rd_v[0] = f0.fifo_rd_en;
    assign rd_v[1] = f1.fifo_rd_en;
    assign rd_v[2] = f2.fifo_rd_en;

    fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en_v[0]), .fifo(f0),
        .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en_v[1]), .fifo(f1),
        .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(16)) u_dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en_v[2]), .fifo(f2),
        .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

    // FIFO model: a read strobe pops the queue, data appears the following cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_v[i] === 1'b1) begin
                if (i != sel || q.size() == 0) begin
                    bad_rd++;
                end else begin
                    fifo_data_m = q.pop_front();
                    rd_cnt++;
                end
            end
        end
        q_empty_m = (q.size() == 0);
    end

    function automatic int cpb_of(input int i);
        case (i)
            0:       return 2;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        q_empty_m = 1'b0;
        pushes++;
    endtask

    // Wait for the start bit and check a whole frame on instance i. exp_bits holds the
    // ten line levels in order (start, d0..d7, stop); exp_gap < 0 skips the gap check.
    task automatic check_frame(input int i, input logic [9:0] exp_bits, input int exp_len,
                               input int exp_gap);
        int         cpb;
        int         gap;
        bit         found;
        int         fd_at;
        int         fd_n;
        bit         busy_ok;
        logic [9:0] seg_bad;
        cpb = cpb_of(i);
        gap = 0;
        found = 1'b0;
        fd_at = -1;
        fd_n = 0;
        busy_ok = 1'b1;
        seg_bad = '0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (tx_v[i] === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
        chk("start_seen", found, 1);
        if (!found) return;
        if (exp_gap >= 0) chk("gap_high_cycles", gap, exp_gap);
        for (int c = 1; c <= 10 * cpb; c++) begin
            if (c > 1) @(negedge clk);
            if (tx_v[i] !== exp_bits[(c - 1) / cpb]) seg_bad[(c - 1) / cpb] = 1'b1;
            if (fd_v[i] === 1'b1) begin
                fd_n++;
                if (fd_at < 0) fd_at = c;
            end
            if (busy_v[i] !== 1'b1) busy_ok = 1'b0;
        end
        for (int s = 0; s < 10; s++) begin
            chk($sformatf("frame_seg%0d_wrong_level", s), seg_bad[s], 0);
        end
        chk("frame_done_cycle", fd_at, exp_len);
        chk("frame_done_count", fd_n, 1);
        chk("busy_in_frame", busy_ok, 1);
        @(posedge clk);
        #1;
        chk("busy_fall", busy_v[i], 0);
        chk("tx_idle_after", tx_v[i], 1);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [9:0] bits;
        int         len;
    } vec_t;

    vec_t vt[6];

    initial begin
        int rd0;
        bit ok_rd;
        bit ok_tx;
        bit found;

        vt[0] = '{1, 8'h05, 10'b1000001010, 40};
        vt[1] = '{0, 8'h05, 10'b1000001010, 20};
        vt[2] = '{2, 8'h05, 10'b1000001010, 160};
        vt[3] = '{1, 8'hA5, 10'b1101001010, 40};
        vt[4] = '{0, 8'hFF, 10'b1111111110, 20};
        vt[5] = '{2, 8'h00, 10'b1000000000, 160};

        // reset held with data available and enable high
        rst = 1'b1;
        sel = 1;
        push(vt[0].data);
        tx_en_v = 3'b010;
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_outputs", {tx_v, rd_v, busy_v, fd_v}, 12'hE00);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rd_pulse_after_release", rd_v[1], 1);
        @(negedge clk);
        chk("rd_pulse_single", rd_v[1], 0);
        check_frame(1, vt[0].bits, vt[0].len, 0);
        chk("reads_after_reset_frame", rd_cnt, 1);
        tx_en_v = 3'b000;

        // single bytes across the three dividers
        for (int v = 1; v < 6; v++) begin
            rd0 = rd_cnt;
            sel = vt[v].inst;
            push(vt[v].data);
            @(negedge clk);
            tx_en_v[vt[v].inst] = 1'b1;
            check_frame(vt[v].inst, vt[v].bits, vt[v].len, 2);
            tx_en_v = 3'b000;
            chk("reads_per_vector", rd_cnt - rd0, 1);
        end

        // empty FIFO with enable high, then data with enable low
        sel = 2;
        rd0 = rd_cnt;
        @(negedge clk);
        tx_en_v[2] = 1'b1;
        ok_rd = 1'b1;
        ok_tx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (rd_v[2] !== 1'b0) ok_rd = 1'b0;
            if (tx_v[2] !== 1'b1) ok_tx = 1'b0;
        end
        chk("empty_gate_no_read", ok_rd, 1);
        chk("empty_gate_tx_high", ok_tx, 1);
        tx_en_v[2] = 1'b0;
        push(8'h3C);
        ok_rd = 1'b1;
        ok_tx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (rd_v[2] !== 1'b0) ok_rd = 1'b0;
            if (tx_v[2] !== 1'b1) ok_tx = 1'b0;
        end
        chk("enable_gate_no_read", ok_rd, 1);
        chk("enable_gate_tx_high", ok_tx, 1);
        tx_en_v[2] = 1'b1;
        @(negedge clk);
        chk("read_after_enable", rd_v[2], 1);
        check_frame(2, 10'b1001111000, 160, 1);
        tx_en_v = 3'b000;
        chk("reads_gating", rd_cnt - rd0, 1);

        // back-to-back bytes
        sel = 1;
        rd0 = rd_cnt;
        push(8'h05);
        push(8'h0A);
        @(negedge clk);
        tx_en_v[1] = 1'b1;
        check_frame(1, 10'b1000001010, 40, 2);
        check_frame(1, 10'b1000010100, 40, 3);
        ok_rd = 1'b1;
        ok_tx = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rd_v[1] !== 1'b0) ok_rd = 1'b0;
            if (tx_v[1] !== 1'b1) ok_tx = 1'b0;
        end
        chk("b2b_no_read_when_empty", ok_rd, 1);
        chk("b2b_line_idle", ok_tx, 1);
        tx_en_v = 3'b000;
        chk("b2b_reads", rd_cnt - rd0, 2);

        // reset in the middle of data bit 3 of 0xC3 (bit 3 is 0)
        rd0 = rd_cnt;
        push(8'hC3);
        @(negedge clk);
        tx_en_v[1] = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (tx_v[1] === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("midreset_start_seen", found, 1);
        repeat (16) @(negedge clk);
        chk("midreset_bit3_level", tx_v[1], 0);
        #2 rst = 1'b0;
        #1;
        chk("midreset_tx_async", tx_v[1], 1);
        chk("midreset_busy_async", busy_v[1], 0);
        repeat (3) @(negedge clk);
        push(8'h3C);
        rst = 1'b1;
        check_frame(1, 10'b1001111000, 40, 2);
        tx_en_v = 3'b000;
        chk("midreset_reads", rd_cnt - rd0, 2);
        chk("midreset_queue_drained", q.size(), 0);

        // randomized bursts with a one-cycle tx_en drop inside the first frame
        for (int it = 0; it < 8; it++) begin
            int         ri;
            int         nb;
            int         k;
            logic [7:0] bytes[$];
            ri = $urandom_range(0, 2);
            nb = $urandom_range(1, 3);
            k = $urandom_range(5, 10 * cpb_of(ri));
            sel = ri;
            rd0 = rd_cnt;
            bytes.delete();
            for (int j = 0; j < nb; j++) begin
                bytes.push_back(8'($urandom_range(0, 255)));
                push(bytes[j]);
            end
            @(negedge clk);
            fork
                begin
                    automatic int gi = ri;
                    automatic int gk = k;
                    repeat (gk) @(negedge clk);
                    tx_en_v[gi] = 1'b0;
                    @(negedge clk);
                    tx_en_v[gi] = 1'b1;
                end
            join_none
            tx_en_v[ri] = 1'b1;
            for (int j = 0; j < nb; j++) begin
                check_frame(ri, {1'b1, bytes[j], 1'b0}, 10 * cpb_of(ri), (j == 0) ? 2 : 3);
            end
            tx_en_v = 3'b000;
            chk("random_reads", rd_cnt - rd0, nb);
        end

        repeat (5) @(negedge clk);
        chk("no_underflow_or_stray_reads", bad_rd, 0);
        chk("reads_total", rd_cnt, pushes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
